// File: rtl/eth_rx_deframer.sv
// -----------------------------------------------------------------------------
// eth_rx_deframer
//
// Receives the byte stream from an RGMII DDR capture stage. It finds the
// preamble and SFD, strips the 4-byte FCS, checks CRC-32, length and PHY errors,
// and presents the payload as an AXI-Stream-like output with no backpressure.
//
// Ports
//   RGMII_RX_CLK   in   1   receive clock; all logic runs on its rising edge
//   RESET          in   1   synchronous active-high reset
//   RX_DV          in   1   byte valid
//   RX_ER          in   1   PHY receive error (ignored while RX_DV=0)
//   RX_D           in   8   received byte
//   M_TDATA        out  8   payload byte, FCS stripped
//   M_TVALID       out  1   M_TDATA valid (no backpressure)
//   M_TLAST        out  1   last payload byte of the frame
//   M_TUSER        out  1   frame bad; meaningful only with M_TLAST
//   FRAME_OK_CNT   out 16   good-frame counter (saturating)
//   FRAME_BAD_CNT  out 16   bad-frame counter (saturating)
//   DBG_STATE      out  2   FSM state: 0 IDLE, 1 PREAMBLE, 2 PAYLOAD, 3 DROP
//
// Handshake: a beat is transferred in every cycle where M_TVALID=1. There is
// no ready signal, so the consumer must accept every beat. M_TLAST and M_TUSER
// are 0 whenever M_TVALID=0.
// -----------------------------------------------------------------------------
module eth_rx_deframer #(
  parameter int MAX_FRAME = 1518,
  parameter int MIN_FRAME = 64
) (
  input  logic        RGMII_RX_CLK,
  input  logic        RESET,
  input  logic        RX_DV,
  input  logic        RX_ER,
  input  logic [7:0]  RX_D,
  output logic [7:0]  M_TDATA,
  output logic        M_TVALID,
  output logic        M_TLAST,
  output logic        M_TUSER,
  output logic [15:0] FRAME_OK_CNT,
  output logic [15:0] FRAME_BAD_CNT,
  output logic [1:0]  DBG_STATE
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_DROP     = 2'd3
  } state_t;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [11:0] MIN_LEN     = 12'(MIN_FRAME);
  localparam logic [11:0] MAX_LEN     = 12'(MAX_FRAME);
  // A byte is known to be payload once 4 more bytes (the FCS candidates)
  // have arrived behind it, so the line holds 5 bytes.
  localparam logic [11:0] DLY_DEPTH   = 12'd5;

  state_t      r_state;
  logic [2:0]  r_pre_cnt;
  logic [7:0]  r_dly [5];
  logic [11:0] r_len;
  logic [31:0] r_crc;
  logic        r_err;
  // Stage between the delay line and the output register. It gives the
  // one-cycle lag after byte k+5 is sampled.
  logic        r_pend_vld;
  logic        r_pend_last;
  logic        r_pend_user;
  logic [7:0]  r_pend_data;
  logic        r_tvalid;
  logic        r_tlast;
  logic        r_tuser;
  logic [7:0]  r_tdata;
  logic [15:0] r_ok_cnt;
  logic [15:0] r_bad_cnt;

  logic [31:0] w_crc_next;
  logic [11:0] w_len_next;
  logic        w_frame_bad;
  logic        w_runt;
  logic        w_ok_inc;
  logic        w_bad_inc;

  // One byte of reflected CRC-32, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] v;
    v = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      v = v[0] ? ((v >> 1) ^ CRC_POLY) : (v >> 1);
    end
    return v;
  endfunction

  assign w_crc_next  = crc32_byte(r_crc, RX_D);
  assign w_len_next  = (r_len == 12'hFFF) ? r_len : r_len + 12'd1;
  // Used in the cycle RX_DV drops, when r_crc and r_len already cover all bytes.
  assign w_frame_bad = (r_crc != CRC_RESIDUE) || r_err || (r_len < MIN_LEN) || (r_len > MAX_LEN);
  assign w_runt      = (r_state == ST_PAYLOAD) && !RX_DV && (r_len < DLY_DEPTH);
  assign w_ok_inc    = r_pend_vld && r_pend_last && !r_pend_user;
  assign w_bad_inc   = (r_pend_vld && r_pend_last && r_pend_user) || w_runt;

  always_ff @(posedge RGMII_RX_CLK) begin
    if (RESET) begin
      r_state     <= ST_DROP;
      r_pre_cnt   <= 3'd0;
      for (int i = 0; i < 5; i++) r_dly[i] <= 8'h00;
      r_len       <= 12'd0;
      r_crc       <= 32'd0;
      r_err       <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_last <= 1'b0;
      r_pend_user <= 1'b0;
      r_pend_data <= 8'h00;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_tdata     <= 8'h00;
      r_ok_cnt    <= 16'd0;
      r_bad_cnt   <= 16'd0;
    end else begin
      // The output stage always drains the pending stage, which runs
      // independently of the FSM. This lets a TLAST beat overlap the next preamble.
      r_tvalid    <= r_pend_vld;
      r_tlast     <= r_pend_last;
      r_tuser     <= r_pend_user;
      r_tdata     <= r_pend_data;
      r_pend_vld  <= 1'b0;
      r_pend_last <= 1'b0;
      r_pend_user <= 1'b0;

      if (w_ok_inc && (r_ok_cnt != 16'hFFFF)) r_ok_cnt <= r_ok_cnt + 16'd1;
      if (w_bad_inc && (r_bad_cnt != 16'hFFFF)) r_bad_cnt <= r_bad_cnt + 16'd1;

      case (r_state)
        ST_IDLE: begin
          if (RX_DV) begin
            if (RX_D == 8'h55) begin
              r_state   <= ST_PREAMBLE;
              r_pre_cnt <= 3'd1;
            end else begin
              r_state <= ST_DROP;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!RX_DV) begin
            r_state <= ST_IDLE;
          end else if (RX_D == 8'h55) begin
            if (r_pre_cnt == 3'd7) r_state <= ST_DROP;
            else r_pre_cnt <= r_pre_cnt + 3'd1;
          end else if (RX_D == 8'hD5) begin
            r_state <= ST_PAYLOAD;
            r_len   <= 12'd0;
            r_crc   <= CRC_INIT;
            r_err   <= 1'b0;
          end else begin
            r_state <= ST_DROP;
          end
        end
        ST_PAYLOAD: begin
          if (RX_DV) begin
            for (int i = 4; i > 0; i--) r_dly[i] <= r_dly[i-1];
            r_dly[0] <= RX_D;
            r_len    <= w_len_next;
            r_crc    <= w_crc_next;
            if (RX_ER) r_err <= 1'b1;
            // The oldest byte is now followed by 5 more, so it cannot be FCS.
            if (r_len >= DLY_DEPTH) begin
              r_pend_vld  <= 1'b1;
              r_pend_data <= r_dly[4];
            end
          end else begin
            r_state <= ST_IDLE;
            // r_dly[4] is the last byte before the 4 FCS bytes.
            if (r_len >= DLY_DEPTH) begin
              r_pend_vld  <= 1'b1;
              r_pend_last <= 1'b1;
              r_pend_user <= w_frame_bad;
              r_pend_data <= r_dly[4];
            end
          end
        end
        ST_DROP: begin
          if (!RX_DV) r_state <= ST_IDLE;
        end
        default: r_state <= ST_DROP;
      endcase
    end
  end

  assign M_TDATA       = r_tdata;
  assign M_TVALID      = r_tvalid;
  assign M_TLAST       = r_tlast;
  assign M_TUSER       = r_tuser;
  assign FRAME_OK_CNT  = r_ok_cnt;
  assign FRAME_BAD_CNT = r_bad_cnt;
  assign DBG_STATE     = r_state;

endmodule

// File: tb/tb_eth_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_eth_rx_deframer
//
// Directed and randomized frames for eth_rx_deframer. The reference model
// works at the frame level. It takes the bytes after the SFD and gives the
// payload beats, the good/bad verdict and the counter values. The FCS is
// checked by recomputing it with a table-driven CRC over the payload.
// -----------------------------------------------------------------------------
module tb_eth_rx_deframer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic        rst;
  logic        dv;
  logic        er;
  logic [7:0]  d;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tuser;
  logic [15:0] ok_cnt;
  logic [15:0] bad_cnt;
  logic [1:0]  dbg_state;

  eth_rx_deframer #(.MAX_FRAME(1518), .MIN_FRAME(64)) u_dut (
    .RGMII_RX_CLK (clk),
    .RESET        (rst),
    .RX_DV        (dv),
    .RX_ER        (er),
    .RX_D         (d),
    .M_TDATA      (m_tdata),
    .M_TVALID     (m_tvalid),
    .M_TLAST      (m_tlast),
    .M_TUSER      (m_tuser),
    .FRAME_OK_CNT (ok_cnt),
    .FRAME_BAD_CNT(bad_cnt),
    .DBG_STATE    (dbg_state)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned cyc         = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  logic [9:0]  obs_q[$];     // {user, last, data}
  int unsigned obs_cyc_q[$];
  int          stray = 0;    // TLAST/TUSER seen with TVALID low
  always @(negedge clk) begin
    if (m_tvalid === 1'b1) begin
      obs_q.push_back({m_tuser, m_tlast, m_tdata});
      obs_cyc_q.push_back(cyc);
    end else if (m_tlast === 1'b1 || m_tuser === 1'b1) begin
      stray++;
    end
  end

  // ---------------- scoreboard / model ----------------
  logic [9:0]  exp_q[$];
  int          exp_ok  = 0;
  int          exp_bad = 0;
  logic [7:0]  frm_q[$];     // bytes after SFD, FCS included
  bit          er_q[$];
  logic [9:0]  raw_q[$];     // {dv, er, d} per cycle
  int          mark_idx = -1;
  int          rst_idx  = -1;
  int unsigned mark_cyc = 0;
  logic        snap_v, snap_l, snap_u;
  logic [7:0]  snap_d;
  logic [15:0] snap_ok, snap_bad;
  logic [1:0]  snap_st;
  logic [31:0] crc_tbl[256];

  function automatic logic [31:0] fcs_of(input int cnt);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < cnt; i++) c = (c >> 8) ^ crc_tbl[c[7:0] ^ frm_q[i]];
    return ~c;
  endfunction

  task automatic make_frame(input int npay, input bit ramp);
    logic [31:0] f;
    frm_q.delete(); er_q.delete();
    for (int i = 0; i < npay; i++) frm_q.push_back(ramp ? 8'(i) : 8'($urandom));
    f = fcs_of(npay);
    frm_q.push_back(f[7:0]);  frm_q.push_back(f[15:8]);
    frm_q.push_back(f[23:16]); frm_q.push_back(f[31:24]);
    for (int i = 0; i < npay + 4; i++) er_q.push_back(1'b0);
  endtask

  task automatic make_junk(input int n);
    frm_q.delete(); er_q.delete();
    for (int i = 0; i < n; i++) begin
      frm_q.push_back(8'($urandom));
      er_q.push_back(1'b0);
    end
  endtask

  // Frame-level reference: beats, verdict and counters from frm_q / er_q.
  task automatic model_frame();
    int n; bit bad; logic [31:0] fcs_rx;
    n = frm_q.size();
    if (n < 5) begin
      exp_bad++;
    end else begin
      fcs_rx = {frm_q[n-1], frm_q[n-2], frm_q[n-3], frm_q[n-4]};
      bad = (fcs_rx != fcs_of(n - 4)) || (n < 64) || (n > 1518);
      foreach (er_q[i]) if (er_q[i]) bad = 1'b1;
      for (int i = 0; i < n - 4; i++)
        exp_q.push_back({(i == n - 5) ? bad : 1'b0, (i == n - 5), frm_q[i]});
      if (bad) exp_bad++; else exp_ok++;
    end
  endtask

  // ---------------- driver ----------------
  task automatic queue_frame(input int npre, input bit do_model);
    for (int i = 0; i < npre; i++) raw_q.push_back({2'b10, 8'h55});
    raw_q.push_back({2'b10, 8'hD5});
    mark_idx = raw_q.size();
    foreach (frm_q[i]) raw_q.push_back({1'b1, er_q[i], frm_q[i]});
    if (do_model) model_frame();
  endtask

  // Idle cycles carry random RX_D/RX_ER, which the DUT must ignore.
  task automatic queue_gap(input int n);
    for (int i = 0; i < n; i++) raw_q.push_back({1'b0, 1'($urandom), 8'($urandom)});
  endtask

  task automatic run_raw();
    for (int i = 0; i < raw_q.size(); i++) begin
      dv  = raw_q[i][9];
      er  = raw_q[i][8];
      d   = raw_q[i][7:0];
      rst = (i == rst_idx);
      @(posedge clk); #1;
      if (i == mark_idx) mark_cyc = cyc;
      if (i == rst_idx) begin
        snap_v = m_tvalid; snap_l = m_tlast; snap_u = m_tuser; snap_d = m_tdata;
        snap_ok = ok_cnt; snap_bad = bad_cnt; snap_st = dbg_state;
      end
    end
    raw_q.delete();
    rst = 1'b0; dv = 1'b0; er = 1'b0;
    rst_idx = -1;
  endtask

  task automatic clear_sb();
    obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; dv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;   // one RX_DV=0 cycle to leave DROP
    exp_ok = 0; exp_bad = 0;
    clear_sb();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; dv = 1'b1; er = 1'b1; d = 8'h55;
    @(posedge clk); #1; @(posedge clk); #1;
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid got %b exp 0", m_tvalid); end
    vectors++; if (m_tlast !== 1'b0 || m_tuser !== 1'b0) begin miscompares++; $display("FAIL reset_last_user got %b%b exp 00", m_tlast, m_tuser); end
    vectors++; if (m_tdata !== 8'h00) begin miscompares++; $display("FAIL reset_tdata got %h exp 00", m_tdata); end
    vectors++; if (ok_cnt !== 16'd0 || bad_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_counters got %0d/%0d exp 0/0", ok_cnt, bad_cnt); end
    vectors++; if (dbg_state !== 2'd3) begin miscompares++; $display("FAIL reset_state got %0d exp 3 (DROP)", dbg_state); end
    do_reset();
  endtask

  task automatic test_valid_frame();
    do_reset();
    make_frame(60, 1'b1);
    queue_frame(7, 1'b1);
    queue_gap(12);
    run_raw();
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL valid_beats got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL valid_beat[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    vectors++; if (obs_cyc_q.size() == 0 || obs_cyc_q[0] - mark_cyc != 6) begin miscompares++; $display("FAIL valid_latency got %0d exp 6", (obs_cyc_q.size() == 0) ? -1 : int'(obs_cyc_q[0] - mark_cyc)); end
    vectors++; if (ok_cnt !== 16'(exp_ok) || bad_cnt !== 16'(exp_bad)) begin miscompares++; $display("FAIL valid_counters got %0d/%0d exp %0d/%0d", ok_cnt, bad_cnt, exp_ok, exp_bad); end
  endtask

  task automatic test_bad_crc();
    do_reset();
    make_frame(60, 1'b1);
    frm_q[16] = 8'h11;   // byte 0x10 corrupted after FCS was computed
    queue_frame(7, 1'b1);
    queue_gap(12);
    run_raw();
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL crc_beats got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL crc_beat[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    vectors++; if (ok_cnt !== 16'd0 || bad_cnt !== 16'd1) begin miscompares++; $display("FAIL crc_counters got %0d/%0d exp 0/1", ok_cnt, bad_cnt); end
  endtask

  task automatic test_rx_er();
    do_reset();
    make_frame(60, 1'b1);
    er_q[10] = 1'b1;
    queue_frame(7, 1'b1);
    queue_gap(12);
    run_raw();
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rxer_beats got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rxer_beat[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    vectors++; if (ok_cnt !== 16'd0 || bad_cnt !== 16'd1) begin miscompares++; $display("FAIL rxer_counters got %0d/%0d exp 0/1", ok_cnt, bad_cnt); end
  endtask

  task automatic test_bad_preamble();
    do_reset();
    raw_q.push_back({2'b10, 8'h55}); raw_q.push_back({2'b10, 8'h55});
    raw_q.push_back({2'b10, 8'h55}); raw_q.push_back({2'b10, 8'hAA});
    for (int i = 0; i < 70; i++) raw_q.push_back({1'b1, 1'($urandom), 8'($urandom)});
    queue_gap(3);
    run_raw();
    vectors++; if (obs_q.size() != 0 || ok_cnt !== 16'd0 || bad_cnt !== 16'd0) begin miscompares++; $display("FAIL preamble_drop got beats=%0d cnt=%0d/%0d exp 0 0/0", obs_q.size(), ok_cnt, bad_cnt); end
    make_frame(60, 1'b0);
    queue_frame(7, 1'b1);
    queue_gap(12);
    run_raw();
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL preamble_next_beats got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL preamble_next_beat[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    vectors++; if (ok_cnt !== 16'd1 || bad_cnt !== 16'd0) begin miscompares++; $display("FAIL preamble_next_counters got %0d/%0d exp 1/0", ok_cnt, bad_cnt); end
  endtask

  task automatic test_mid_frame_reset();
    localparam int RST_AT = 20;
    do_reset();
    make_frame(60, 1'b1);
    queue_frame(7, 1'b0);
    rst_idx = mark_idx + RST_AT;
    // Beat k appears 6 cycles after byte k; only beats before the reset edge survive.
    for (int k = 0; k + 6 < RST_AT; k++) exp_q.push_back({2'b00, frm_q[k]});
    queue_gap(3);
    run_raw();
    vectors++; if (snap_v !== 1'b0 || snap_l !== 1'b0 || snap_u !== 1'b0 || snap_d !== 8'h00) begin miscompares++; $display("FAIL midreset_outputs got v%b l%b u%b d%h exp all 0", snap_v, snap_l, snap_u, snap_d); end
    vectors++; if (snap_st !== 2'd3 || snap_ok !== 16'd0 || snap_bad !== 16'd0) begin miscompares++; $display("FAIL midreset_state got st%0d cnt %0d/%0d exp 3 0/0", snap_st, snap_ok, snap_bad); end
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL midreset_beats got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL midreset_beat[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    exp_ok = 0; exp_bad = 0;
    clear_sb();
    make_frame(60, 1'b0);
    queue_frame(7, 1'b1);
    queue_gap(12);
    run_raw();
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL midreset_next_beats got %0d exp %0d", obs_q.size(), exp_q.size()); end
    vectors++; if (ok_cnt !== 16'd1 || bad_cnt !== 16'd0) begin miscompares++; $display("FAIL midreset_next_counters got %0d/%0d exp 1/0", ok_cnt, bad_cnt); end
  endtask

  task automatic test_runts();
    do_reset();
    make_junk(3);
    queue_frame(7, 1'b1);
    queue_gap(12);
    run_raw();
    vectors++; if (obs_q.size() != 0 || bad_cnt !== 16'd1 || ok_cnt !== 16'd0) begin miscompares++; $display("FAIL runt3 got beats=%0d cnt=%0d/%0d exp 0 0/1", obs_q.size(), ok_cnt, bad_cnt); end
    make_junk(5);
    queue_frame(7, 1'b1);
    queue_gap(12);
    run_raw();
    vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL runt5_beats got %0d exp 1", obs_q.size()); end
    vectors++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin miscompares++; $display("FAIL runt5_beat got %h exp %h", (obs_q.size() > 0) ? obs_q[0] : 10'h0, exp_q[0]); end
    vectors++; if (ok_cnt !== 16'd0 || bad_cnt !== 16'd2) begin miscompares++; $display("FAIL runt5_counters got %0d/%0d exp 0/2", ok_cnt, bad_cnt); end
  endtask

  task automatic test_length_limits();
    int lens[4] = '{63, 64, 1518, 1519};
    do_reset();
    foreach (lens[j]) begin
      make_frame(lens[j] - 4, 1'b0);
      queue_frame(7, 1'b1);
      queue_gap(1);
    end
    queue_gap(12);
    run_raw();
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL limits_beats got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL limits_beat[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    vectors++; if (ok_cnt !== 16'd2 || bad_cnt !== 16'd2) begin miscompares++; $display("FAIL limits_counters got %0d/%0d exp 2/2", ok_cnt, bad_cnt); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    for (int f = 0; f < 12; f++) begin
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 120);
      if (n < 5) begin
        make_junk(n);
      end else begin
        make_frame(n - 4, 1'b0);
        if ($urandom_range(0, 3) == 0) begin
          int p;
          p = $urandom_range(0, n - 1);
          frm_q[p] = frm_q[p] ^ (8'h01 << $urandom_range(0, 7));
        end
        if ($urandom_range(0, 5) == 0) er_q[$urandom_range(0, n - 1)] = 1'b1;
      end
      queue_frame($urandom_range(1, 7), 1'b1);
      queue_gap($urandom_range(1, 3));
    end
    queue_gap(12);
    run_raw();
    vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL b2b_beats got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_beat[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    vectors++; if (ok_cnt !== 16'(exp_ok) || bad_cnt !== 16'(exp_bad)) begin miscompares++; $display("FAIL b2b_counters got %0d/%0d exp %0d/%0d", ok_cnt, bad_cnt, exp_ok, exp_bad); end
  endtask

  task automatic test_idle_outputs();
    vectors++; if (stray != 0) begin miscompares++; $display("FAIL idle_last_user got %0d cycles exp 0", stray); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tbl[i] = c;
    end
    rst = 1'b1; dv = 1'b0; er = 1'b0; d = 8'h00;
    test_reset();
    test_valid_frame();
    test_bad_crc();
    test_rx_er();
    test_bad_preamble();
    test_mid_frame_reset();
    test_runts();
    test_length_limits();
    test_back_to_back();
    test_idle_outputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
